ct_wrr_sched: RTL and testbench
===============================

# ct_wrr_sched

Packet-granular weighted round-robin scheduler that drives the select of a cut-through merge datapath. It grants one of NI requesters at a time and holds the grant for a whole packet. It lets a requester keep the grant for up to its configured weight of packets per turn before moving on in round-robin order. The block sits beside the merge and supplies its select and per-input ready qualification, so the merge itself needs no arbitration logic.

## Interface
- NI, 4, number of requesters (≥1)
- WBITS, 4, width of each per-input weight (packets per turn)
- NIBITS, max(1, clog2(NI)), derived, width of o_sel; not overridable
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; state cleared on any clk edge where reset==0
- i_req  in  NI  requester i has a beat available
- i_weight  in  NI*WBITS  packets per turn, input i at [WBITS*i +: WBITS]; 0 = input disabled
- i_xfer  in  1  a beat of the granted input was accepted downstream this cycle
- i_eop  in  1  the accepted beat is last of packet; qualified by i_xfer
- o_grant_valid  out  1  a grant is held
- o_grant  out  NI  one-hot grant; all-zero when o_grant_valid==0
- o_sel  out  NIBITS  binary index of granted input, to the merge select
- o_err  out  1  sticky protocol error

## Operation
- Eligible mask: i_req[i] && i_weight[i]!=0.
- Round-robin pick: first eligible index scanning ptr+1, ptr+2, … ptr (mod NI). The last granted input is lowest priority. The pick re-grants it only if nothing else is eligible.
- States: IDLE (no grant), GAP (granted, no packet in progress), ACTIVE (granted, packet in progress).
- IDLE: if any eligible, go to GAP with grant=pick, count=0, wlat=i_weight[pick]. Otherwise stay.
- GAP with i_xfer && !i_eop: go to ACTIVE.
- GAP with i_xfer && i_eop: run end-of-packet handling.
- GAP with !i_xfer && !i_req[cur]: release.
- GAP with !i_xfer && i_req[cur]: stay.
- ACTIVE: never released mid-packet, even if i_req[cur] drops. On i_xfer && i_eop, run end-of-packet handling. Otherwise stay.
- End-of-packet handling: cnt_n=count+1. If cnt_n ≥ wlat, release. Otherwise go to GAP with count=cnt_n.
- Release: ptr←cur. Pick on this cycle's eligible mask. If found, go to GAP with a new grant, count=0 and wlat latched. Otherwise go to IDLE.
- Weight is latched at grant. Changes to i_weight mid-turn take effect at the next grant.
- i_xfer in IDLE, or on the cycle a release is registered: ignored, and o_err←1 until reset.
- count width WBITS. wlat ≥1 is guaranteed by eligibility, so count never wraps.

## Timing
- Reset values: state IDLE, o_grant_valid=0, o_grant=0, o_sel=0, o_err=0, count=0, ptr=NI-1 (input 0 wins first).
- Reset mid-packet: grant drops on the edge that samples reset==0. No packet completion is inferred.
- All outputs are registered. There is no combinational path from any input to any output.
- From an eligible request in IDLE to o_grant_valid=1: 1 cycle.
- Handover at release is bubble-free. If the eop beat or GAP release is in cycle N, the new grant is visible in N+1.
- Back-to-back packets within a turn: grant unchanged, 0 dead cycles.
- Simultaneous eop and a new request from another input: the new input is considered in the same-cycle pick.

## Structure
- Package ct_sched_pkg holds:
  - the state enum (IDLE, GAP, ACTIVE);
  - the clog2 function with a minimum of 1, used for NIBITS.
- Sub-module ct_rr_pick is combinational. Inputs: eligible mask [NI], pointer [NIBITS]. Outputs: found, index [NIBITS].
- Top level contains:
  - the FSM;
  - the count, wlat and ptr registers;
  - the error flag;
  - the one-hot decode of o_sel.

## Test plan
- Reset: reset=0 for 3 cycles with i_req=4'b1111 and weights all 1, giving all outputs 0. Then reset=1 with single-beat packets, i_xfer=i_eop=1 every granted cycle. Required: o_sel 0,1,2,3,0,… one cycle after release, no gaps.
- Weights {1,1,1,3} (input 0 weight 3), all requesting, single-beat packets. Required: o_sel sequence 0,0,0,1,2,3,0,0,0.
- Only input 1 requesting, weight 1, 4-beat packet, i_req[1] low during beat 2 stall. Required: grant held until the eop beat, then re-granted to 1 next cycle with count=0.
- Input 0 weight 4 sends 1 packet, then i_req[0]=0 while i_req[2]=1. Required: in GAP, release is taken and o_sel=2 the next cycle.
- i_weight[3]=0 with i_req[3]=1 alone. Required: stays IDLE, o_grant_valid=0.
- i_xfer=1 while IDLE. Required: o_err=1 next cycle and held through further traffic until reset=0.

Source files
------------

// File: rtl/ct_wrr_sched_pkg.sv
// ct_sched_pkg: shared types and helpers for the ct_wrr_sched scheduler.
//   sched_state_e : scheduler state (IDLE = no grant, GAP = granted between
//                   packets, ACTIVE = granted with a packet in flight).
//   clog2_min1    : ceil(log2(n)) clamped to at least 1, so that a single
//                   requester still gets a 1-bit select.
package ct_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GAP    = 2'd1,
        ST_ACTIVE = 2'd2
    } sched_state_e;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ct_wrr_sched_if.sv
// ct_wrr_sched_if: request/grant bundle between the requesters, the merge
// datapath and the scheduler.
//   i_req[NI]            requester has a beat available
//   i_weight[NI*WBITS]   packets per turn per input, 0 disables the input
//   i_xfer, i_eop        downstream accepted a beat / that beat ends a packet
//   o_grant_valid        a grant is held
//   o_grant[NI]          one-hot grant
//   o_sel[NIBITS]        binary index of the granted input (merge select)
//   o_err                sticky protocol error
// Modport slave is the scheduler side, master the requester/merge side.
interface ct_wrr_sched_if
    import ct_sched_pkg::*;
#(
    parameter int NI    = 4,
    parameter int WBITS = 4
);
    localparam int NIBITS = clog2_min1(NI);

    logic [NI-1:0]       i_req;
    logic [NI*WBITS-1:0] i_weight;
    logic                i_xfer;
    logic                i_eop;
    logic                o_grant_valid;
    logic [NI-1:0]       o_grant;
    logic [NIBITS-1:0]   o_sel;
    logic                o_err;

    modport slave (
        input  i_req, i_weight, i_xfer, i_eop,
        output o_grant_valid, o_grant, o_sel, o_err
    );

    modport master (
        output i_req, i_weight, i_xfer, i_eop,
        input  o_grant_valid, o_grant, o_sel, o_err
    );

endinterface

// File: rtl/ct_wrr_sched_rr_pick.sv
// ct_rr_pick: combinational round-robin picker.
//   elig_mask[NI]  eligible requesters
//   ptr[NIBITS]    last granted index (lowest priority)
//   found          at least one eligible requester
//   index[NIBITS]  first eligible index scanning ptr+1, ptr+2, ... ptr
module ct_rr_pick
    import ct_sched_pkg::*;
#(
    parameter int NI     = 4,
    parameter int NIBITS = clog2_min1(NI)
) (
    input  logic [NI-1:0]     elig_mask,
    input  logic [NIBITS-1:0] ptr,
    output logic              found,
    output logic [NIBITS-1:0] index
);

    // Scan farthest-to-nearest so the nearest eligible index after ptr wins.
    always_comb begin
        int cand;
        found = 1'b0;
        index = {NIBITS{1'b0}};
        cand  = 0;
        for (int k = NI; k >= 1; k--) begin
            cand = (int'(ptr) + k) % NI;
            if (elig_mask[cand]) begin
                found = 1'b1;
                index = cand[NIBITS-1:0];
            end else begin
                found = found;
                index = index;
            end
        end
    end

endmodule

// File: rtl/ct_wrr_sched.sv
// ct_wrr_sched: packet-granular weighted round-robin scheduler driving the
// select of a cut-through merge.
//   clk    sole clock
//   reset  synchronous, active-low
//   bus    ct_wrr_sched_if.slave (requests, weights, beat handshake, grant)
// A grant is held for a whole packet; a requester keeps the grant for up to
// its weight (latched at grant time) of packets per turn. All outputs are
// registered.
module ct_wrr_sched
    import ct_sched_pkg::*;
#(
    parameter int NI    = 4,
    parameter int WBITS = 4
) (
    input  logic           clk,
    input  logic           reset,
    ct_wrr_sched_if.slave  bus
);
    localparam int NIBITS = clog2_min1(NI);

    sched_state_e      state_r, state_n;
    logic              valid_r, valid_n;
    logic [NI-1:0]     grant_r, grant_n;
    logic [NIBITS-1:0] sel_r, sel_n;
    logic [NIBITS-1:0] ptr_r, ptr_n;
    logic [WBITS-1:0]  count_r, count_n;
    logic [WBITS-1:0]  wlat_r, wlat_n;
    logic              err_r, err_n;

    logic [NI-1:0]     elig_s;
    logic [NIBITS-1:0] pick_ptr_s;
    logic [NIBITS-1:0] pick_idx_s;
    logic              pick_found_s;
    logic [WBITS-1:0]  pick_w_s;
    logic [WBITS-1:0]  cnt_inc_s;
    logic              eop_hit_s;
    logic              release_s;

    // Eligibility mask and the weight of the picked input.
    always_comb begin
        elig_s   = {NI{1'b0}};
        pick_w_s = {WBITS{1'b0}};
        for (int i = 0; i < NI; i++) begin
            elig_s[i] = bus.i_req[i] && (bus.i_weight[WBITS*i +: WBITS] != {WBITS{1'b0}});
            if (pick_idx_s == NIBITS'(i)) begin
                pick_w_s = bus.i_weight[WBITS*i +: WBITS];
            end else begin
                pick_w_s = pick_w_s;
            end
        end
    end

    // While a grant is held the current input is the pointer a release will
    // install, so picking from sel_r gives the bubble-free handover pick.
    assign pick_ptr_s = (state_r == ST_IDLE) ? ptr_r : sel_r;

    ct_rr_pick #(
        .NI     (NI),
        .NIBITS (NIBITS)
    ) u_pick (
        .elig_mask (elig_s),
        .ptr       (pick_ptr_s),
        .found     (pick_found_s),
        .index     (pick_idx_s)
    );

    // Next-state, counters, pointer, error flag and one-hot grant decode.
    always_comb begin
        state_n   = state_r;
        valid_n   = valid_r;
        sel_n     = sel_r;
        ptr_n     = ptr_r;
        count_n   = count_r;
        wlat_n    = wlat_r;
        err_n     = err_r;
        grant_n   = {NI{1'b0}};
        eop_hit_s = 1'b0;
        release_s = 1'b0;
        cnt_inc_s = count_r + WBITS'(1'b1);

        case (state_r)
            ST_IDLE: begin
                // A beat accepted with no grant held is a protocol violation.
                err_n = err_r | bus.i_xfer;
                if (pick_found_s) begin
                    state_n = ST_GAP;
                    valid_n = 1'b1;
                    sel_n   = pick_idx_s;
                    count_n = {WBITS{1'b0}};
                    wlat_n  = pick_w_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (bus.i_xfer) begin
                    if (bus.i_eop) begin
                        eop_hit_s = 1'b1;
                    end else begin
                        state_n = ST_ACTIVE;
                    end
                end else if (!bus.i_req[sel_r]) begin
                    release_s = 1'b1;
                end else begin
                    state_n = ST_GAP;
                end
            end
            ST_ACTIVE: begin
                // Held until the eop beat even if the request drops.
                if (bus.i_xfer && bus.i_eop) begin
                    eop_hit_s = 1'b1;
                end else begin
                    state_n = ST_ACTIVE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
                sel_n   = {NIBITS{1'b0}};
                count_n = {WBITS{1'b0}};
            end
        endcase

        // Packet finished: either the turn is used up or wait for the next one.
        if (eop_hit_s) begin
            if (cnt_inc_s >= wlat_r) begin
                release_s = 1'b1;
            end else begin
                state_n = ST_GAP;
                count_n = cnt_inc_s;
            end
        end else begin
            count_n = count_n;
        end

        if (release_s) begin
            ptr_n = sel_r;
            if (pick_found_s) begin
                state_n = ST_GAP;
                valid_n = 1'b1;
                sel_n   = pick_idx_s;
                count_n = {WBITS{1'b0}};
                wlat_n  = pick_w_s;
            end else begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
                sel_n   = {NIBITS{1'b0}};
                count_n = {WBITS{1'b0}};
            end
        end else begin
            ptr_n = ptr_n;
        end

        for (int i = 0; i < NI; i++) begin
            grant_n[i] = valid_n && (sel_n == NIBITS'(i));
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            grant_r <= {NI{1'b0}};
            sel_r   <= {NIBITS{1'b0}};
            ptr_r   <= NIBITS'(NI - 1);
            count_r <= {WBITS{1'b0}};
            wlat_r  <= {WBITS{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            valid_r <= valid_n;
            grant_r <= grant_n;
            sel_r   <= sel_n;
            ptr_r   <= ptr_n;
            count_r <= count_n;
            wlat_r  <= wlat_n;
            err_r   <= err_n;
        end
    end

    assign bus.o_grant_valid = valid_r;
    assign bus.o_grant       = grant_r;
    assign bus.o_sel         = sel_r;
    assign bus.o_err         = err_r;

endmodule

// File: tb/tb_ct_wrr_sched.sv
// tb_ct_wrr_sched: directed scenarios plus randomized traffic for
// ct_wrr_sched, checked every cycle against a turn-based reference model.
module tb_ct_wrr_sched;
    localparam int NI    = 4;
    localparam int WBITS = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    // Reference model: who holds the grant, whether a packet is in flight,
    // packets completed this turn, latched quota, last granted input.
    bit m_has;
    int m_cur;
    bit m_busy;
    int m_done;
    int m_quota;
    int m_last;
    bit m_err;

    int wrr_seq[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};

    ct_wrr_sched_if #(.NI(NI), .WBITS(WBITS)) bus ();

    ct_wrr_sched #(.NI(NI), .WBITS(WBITS)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int weight_of(input int j);
        logic [WBITS-1:0] w;
        w = bus.i_weight[WBITS*j +: WBITS];
        return int'(w);
    endfunction

    // Next requester after 'last' in circular order that wants and may send.
    function automatic int rr_pick(input int last);
        for (int k = 1; k <= NI; k++) begin
            int j;
            j = (last + k) % NI;
            if (bus.i_req[j] && weight_of(j) != 0) return j;
        end
        return -1;
    endfunction

    function automatic void give_turn(input int p);
        m_has   = 1'b1;
        m_cur   = p;
        m_busy  = 1'b0;
        m_done  = 0;
        m_quota = weight_of(p);
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_step();
        bit finish;
        int p;
        finish = 1'b0;
        if (!rst) begin
            m_has = 1'b0; m_cur = 0; m_busy = 1'b0;
            m_done = 0; m_quota = 0; m_last = NI - 1; m_err = 1'b0;
            return;
        end
        if (!m_has) begin
            if (bus.i_xfer) m_err = 1'b1;
            p = rr_pick(m_last);
            if (p >= 0) give_turn(p);
            return;
        end
        if (bus.i_xfer && bus.i_eop) begin
            m_done++;
            m_busy = 1'b0;
            if (m_done >= m_quota) finish = 1'b1;
        end else if (bus.i_xfer) begin
            m_busy = 1'b1;
        end else if (!m_busy && !bus.i_req[m_cur]) begin
            finish = 1'b1;
        end
        if (finish) begin
            m_last = m_cur;
            p = rr_pick(m_cur);
            if (p >= 0) begin
                give_turn(p);
            end else begin
                m_has = 1'b0;
                m_cur = 0;
            end
        end
    endfunction

    task automatic compare_all();
        chk("valid", int'(bus.o_grant_valid), int'(m_has));
        chk("grant", int'(bus.o_grant), m_has ? (1 << m_cur) : 0);
        if (m_has) chk("sel", int'(bus.o_sel), m_cur);
        chk("err", int'(bus.o_err), int'(m_err));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        bus.i_weight = {WBITS'(w3), WBITS'(w2), WBITS'(w1), WBITS'(w0)};
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.i_xfer = 1'b0;
        bus.i_eop  = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.i_req = '0;
        bus.i_weight = '0;
        bus.i_xfer = 1'b0;
        bus.i_eop = 1'b0;
        m_has = 1'b0; m_cur = 0; m_busy = 1'b0;
        m_done = 0; m_quota = 0; m_last = NI - 1; m_err = 1'b0;
        #2;

        // Reset with everyone requesting, then plain round robin.
        bus.i_req = 4'b1111;
        set_w(1, 1, 1, 1);
        repeat (3) begin
            cycle();
            chk("rst_valid", int'(bus.o_grant_valid), 0);
            chk("rst_grant", int'(bus.o_grant), 0);
            chk("rst_sel", int'(bus.o_sel), 0);
            chk("rst_err", int'(bus.o_err), 0);
        end
        rst = 1'b1;
        cycle();
        for (int k = 0; k < 9; k++) begin
            chk("rr_seq", int'(bus.o_sel), k % 4);
            bus.i_xfer = 1'b1;
            bus.i_eop  = 1'b1;
            cycle();
        end

        // Input 0 weight 3.
        set_w(3, 1, 1, 1);
        do_reset();
        cycle();
        for (int k = 0; k < 9; k++) begin
            chk("wrr_seq", int'(bus.o_sel), wrr_seq[k]);
            bus.i_xfer = 1'b1;
            bus.i_eop  = 1'b1;
            cycle();
        end

        // Multi-beat packet with request dropped during a stall.
        set_w(1, 1, 1, 1);
        bus.i_req = 4'b0010;
        do_reset();
        cycle();
        bus.i_xfer = 1'b1; bus.i_eop = 1'b0;
        cycle();
        bus.i_xfer = 1'b0; bus.i_req = 4'b0000;
        repeat (2) begin
            cycle();
            chk("stall_hold_valid", int'(bus.o_grant_valid), 1);
            chk("stall_hold_sel", int'(bus.o_sel), 1);
        end
        bus.i_req = 4'b0010; bus.i_xfer = 1'b1;
        cycle();
        cycle();
        bus.i_eop = 1'b1;
        cycle();
        chk("regrant_valid", int'(bus.o_grant_valid), 1);
        chk("regrant_sel", int'(bus.o_sel), 1);
        cycle();
        chk("regrant2_sel", int'(bus.o_sel), 1);

        // Release from GAP when the holder stops requesting.
        set_w(4, 4, 4, 4);
        bus.i_req = 4'b0001;
        do_reset();
        cycle();
        bus.i_xfer = 1'b1; bus.i_eop = 1'b1;
        cycle();
        chk("gap_hold_sel", int'(bus.o_sel), 0);
        bus.i_xfer = 1'b0; bus.i_eop = 1'b0;
        bus.i_req = 4'b0100;
        cycle();
        chk("gap_release_valid", int'(bus.o_grant_valid), 1);
        chk("gap_release_sel", int'(bus.o_sel), 2);

        // Zero weight disables the input.
        set_w(1, 1, 1, 0);
        bus.i_req = 4'b1000;
        do_reset();
        repeat (4) begin
            cycle();
            chk("w0_idle", int'(bus.o_grant_valid), 0);
        end

        // Transfer while idle sets the sticky error.
        set_w(1, 1, 1, 1);
        bus.i_req = 4'b0000;
        do_reset();
        bus.i_xfer = 1'b1;
        cycle();
        chk("err_set", int'(bus.o_err), 1);
        bus.i_req = 4'b1111;
        bus.i_xfer = 1'b0;
        repeat (10) begin
            bus.i_xfer = m_has;
            bus.i_eop  = 1'b1;
            cycle();
        end
        chk("err_held", int'(bus.o_err), 1);
        rst = 1'b0; bus.i_xfer = 1'b0;
        cycle();
        chk("err_cleared", int'(bus.o_err), 0);
        rst = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            bus.i_req = 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                set_w($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            end
            bus.i_xfer = m_has && ($urandom_range(0, 2) != 0);
            bus.i_eop  = 1'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
